// File: rtl/seg_display_ctrl.sv
// seg_display_ctrl: memory-mapped multiplexed 7-segment display driver.
// Ports: clk, rst (async high), cs/wr_en/wr_data/mode write port,
//   DIG (active-low digit enables), Y (active-low segments, dp=Y[7]), busy.
// Decimal writes go through a shift-add-3 converter, one bit per clock.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg_display_ctrl #(
  parameter int N_DIGITS = 8,
  parameter int DATA_W   = 32,
  parameter int SCAN_DIV = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cs,
  input  logic                wr_en,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                mode,
  output logic [N_DIGITS-1:0] DIG,
  output logic [7:0]          Y,
  output logic                busy
);

  // Decimal digits needed for 2^w-1.
  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        n++;
        v = v / 64'd10;
      end
    end
    return n;
  endfunction

  localparam int BCD_D = dec_digits(DATA_W);
  localparam int HEX_D = (DATA_W + 3) / 4;
  localparam int ND    = (BCD_D > HEX_D) ? BCD_D : HEX_D;
  localparam int BW    = 4 * ND;
  localparam int PD    = (ND > N_DIGITS) ? ND : N_DIGITS;
  localparam int CW    = $clog2(SCAN_DIV);
  localparam int IW    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int KW    = $clog2(DATA_W + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_SHIFT  = 2'd2;
  localparam logic [1:0] S_COMMIT = 2'd3;

  // One double-dabble step: correct every BCD digit, then shift.
  function automatic logic [BW+DATA_W-1:0] dabble(
    input logic [BW-1:0]     b,
    input logic [DATA_W-1:0] s
  );
    logic [BW-1:0] t;
    t = b;
    for (int i = 0; i < ND; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t, s} << 1;
  endfunction

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] y;
    unique case (d)
      4'h0: y = 8'hC0;
      4'h1: y = 8'hF9;
      4'h2: y = 8'hA4;
      4'h3: y = 8'hB0;
      4'h4: y = 8'h99;
      4'h5: y = 8'h92;
      4'h6: y = 8'h82;
      4'h7: y = 8'hF8;
      4'h8: y = 8'h80;
      4'h9: y = 8'h90;
      4'hA: y = 8'h88;
      4'hB: y = 8'h83;
      4'hC: y = 8'hC6;
      4'hD: y = 8'hA1;
      4'hE: y = 8'h86;
      4'hF: y = 8'h8E;
    endcase
    return y;
  endfunction

  logic [1:0]          state, state_n;
  logic [DATA_W-1:0]   sh, sh_n, sh_d;
  logic [BW-1:0]       bcd, bcd_n, bcd_d;
  logic                pmode, pmode_n;
  logic [KW-1:0]       bit_cnt, bit_n;
  logic [BW-1:0]       disp, disp_n;
  logic                written, written_n;
  logic                busy_n;
  logic [CW-1:0]       scan_cnt, scan_n;
  logic [IW-1:0]       idx, idx_n;
  logic [4*PD-1:0]     dpad, upper;
  logic [3:0]          digit;
  logic                ovf, blank;
  logic [7:0]          y_n;
  logic [N_DIGITS-1:0] dig_n;

  always_comb begin
    state_n   = state;
    sh_n      = sh;
    bcd_n     = bcd;
    pmode_n   = pmode;
    bit_n     = bit_cnt;
    disp_n    = disp;
    written_n = written;
    busy_n    = busy;
    {bcd_d, sh_d} = dabble(bcd, sh);
    if (cs && wr_en) begin
      // New write always wins, even over a pending commit.
      state_n = S_LOAD;
      sh_n    = wr_data;
      bcd_n   = '0;
      pmode_n = mode;
      bit_n   = '0;
    end else begin
      case (state)
        S_LOAD: begin
          if (pmode) begin
            disp_n             = '0;
            disp_n[DATA_W-1:0] = sh;
            written_n          = 1'b1;
            busy_n             = 1'b0;
            state_n            = S_IDLE;
          end else begin
            bcd_n   = bcd_d;
            sh_n    = sh_d;
            bit_n   = KW'(1);
            busy_n  = 1'b1;
            state_n = S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_n = bcd_d;
          sh_n  = sh_d;
          bit_n = bit_cnt + KW'(1);
          if (bit_cnt == KW'(DATA_W - 1)) state_n = S_COMMIT;
        end
        S_COMMIT: begin
          disp_n    = bcd;
          written_n = 1'b1;
          busy_n    = 1'b0;
          state_n   = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  always_comb begin
    scan_n = scan_cnt + CW'(1);
    idx_n  = idx;
    if (scan_cnt == CW'(SCAN_DIV - 1)) begin
      scan_n = '0;
      idx_n  = (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
    end
  end

  // Outputs are decoded from next-state values so they are registered
  // yet change on the same edge as the display register.
  always_comb begin
    dpad         = '0;
    dpad[BW-1:0] = disp_n;
    ovf          = 1'b0;
    for (int i = N_DIGITS; i < PD; i++) begin
      if (dpad[4*i +: 4] != 4'd0) ovf = 1'b1;
    end
    digit = dpad[{idx_n, 2'b00} +: 4];
    upper = dpad >> {idx_n, 2'b00};
`ifdef LEADING_ZERO_BLANK_EN
    blank = (idx_n != '0) && (upper == '0);
`else
    blank = 1'b0;
`endif
    if (!written_n)  y_n = 8'hFF;
    else if (ovf)    y_n = 8'hBF;
    else if (blank)  y_n = 8'hFF;
    else             y_n = seg7(digit);
    dig_n = written_n ? ~(N_DIGITS'(1) << idx_n) : '1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      sh       <= '0;
      bcd      <= '0;
      pmode    <= 1'b0;
      bit_cnt  <= '0;
      disp     <= '0;
      written  <= 1'b0;
      busy     <= 1'b0;
      scan_cnt <= '0;
      idx      <= '0;
      DIG      <= '1;
      Y        <= 8'hFF;
    end else begin
      state    <= state_n;
      sh       <= sh_n;
      bcd      <= bcd_n;
      pmode    <= pmode_n;
      bit_cnt  <= bit_n;
      disp     <= disp_n;
      written  <= written_n;
      busy     <= busy_n;
      scan_cnt <= scan_n;
      idx      <= idx_n;
      DIG      <= dig_n;
      Y        <= y_n;
    end
  end

endmodule

// File: tb/tb_seg_display_ctrl.sv
// tb_seg_display_ctrl: directed and random stimulus for seg_display_ctrl,
// checked each cycle against a value-level display model.
module tb_seg_display_ctrl;

  localparam int N  = 4;
  localparam int DW = 17;
  localparam int SD = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [7:0] SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cs = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          mode = 1'b0;
  logic [N-1:0]  DIG;
  logic [7:0]    Y;
  logic          busy;

  seg_display_ctrl #(
    .N_DIGITS(N),
    .DATA_W(DW),
    .SCAN_DIV(SD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cs(cs),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .mode(mode),
    .DIG(DIG),
    .Y(Y),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: edges since reset, shown value, pending write.
  int t;
  bit written;
  int dv;
  bit dm;
  bit pend;
  int pk;
  int pv;
  bit pm;
  bit bm;

  task automatic cmp(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, got, exp, t);
    end
  endtask

  function automatic logic [7:0] exp_y(input int v, input bit hx,
                                       input int i);
    longint b, p, lim;
    int d;
    b   = hx ? 16 : 10;
    lim = b ** N;
    p   = b ** i;
    if (v >= lim) return 8'hBF;
    d = int'((v / p) % b);
    if (LZB && i > 0 && v < p) return 8'hFF;
    return SEG[d];
  endfunction

  task automatic model_reset();
    t = 0; written = 0; dv = 0; dm = 0;
    pend = 0; pk = 0; pv = 0; pm = 0; bm = 0;
  endtask

  // Hex commits one edge after acceptance, decimal DW+1 edges after;
  // any later accepted write replaces the pending one.
  task automatic model_edge();
    t++;
    if (cs && wr_en) begin
      pend = 1; pk = t; pv = int'(wr_data); pm = mode;
    end else if (pend) begin
      if (t == (pm ? pk + 1 : pk + DW + 1)) begin
        written = 1; dv = pv; dm = pm; pend = 0; bm = 0;
      end else begin
        bm = 1;
      end
    end
  endtask

  task automatic check();
    int idx;
    logic [N-1:0] ed;
    logic [7:0] ey;
    idx = (t / SD) % N;
    ed  = written ? ~(4'b1 << idx) : 4'hF;
    ey  = written ? exp_y(dv, dm, idx) : 8'hFF;
    cmp("dig", DIG, ed);
    cmp("y", Y, ey);
    cmp("busy", busy, bm);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wr(input int v, input bit m);
    cs = 1; wr_en = 1; wr_data = DW'(v); mode = m;
    step();
    cs = 0; wr_en = 0; wr_data = DW'($urandom); mode = $urandom_range(0, 1) != 0;
  endtask

  task automatic do_reset();
    rst = 1;
    model_reset();
    #1;
    check();
    @(posedge clk);
    @(negedge clk);
    check();
    rst = 0;
  endtask

  // Over one full scan, Y for each enabled digit must match a literal.
  task automatic scan_lits(input logic [7:0] l0, input logic [7:0] l1,
                           input logic [7:0] l2, input logic [7:0] l3);
    logic [7:0] l [4];
    int d;
    l = '{l0, l1, l2, l3};
    for (int c = 0; c < N * SD; c++) begin
      step();
      d = -1;
      for (int j = 0; j < N; j++) if (DIG[j] == 1'b0) d = j;
      if (d < 0) cmp("scan_dig", DIG, 4'hE);
      else cmp("scan_y", Y, l[d]);
    end
  endtask

  initial begin
    int bcount;
    bit saw;
    logic [7:0] z;
    z = LZB ? 8'hFF : 8'hC0;
    #1;
    do_reset();

    // Blank while nothing has been written.
    saw = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (DIG !== 4'hF || Y !== 8'hFF || busy !== 1'b0) saw = 1;
    end
    cmp("idle_blank", saw, 0);

    // Decimal 1234: busy for exactly DW edges, then commit.
    wr(1234, 0);
    bcount = 0;
    for (int i = 0; i < DW; i++) begin
      step();
      if (busy === 1'b1) bcount++;
    end
    cmp("busy_len", bcount, DW);
    step();
    cmp("busy_end", busy, 0);
    scan_lits(8'h99, 8'hB0, 8'hA4, 8'hF9);

    // Hex 0BEEF shows on the next edge, never busy.
    wr(17'h0BEEF, 1);
    cmp("hex_busy", busy, 0);
    scan_lits(8'h8E, 8'h86, 8'h86, 8'h83);

    // Decimal overflow of four digits.
    wr(12345, 0);
    idle(DW + 1);
    scan_lits(8'hBF, 8'hBF, 8'hBF, 8'hBF);

    // Abort: 1234 replaced by 7 four edges later.
    wr(1234, 0);
    saw = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (Y === 8'hB0 || Y === 8'hA4) saw = 1;
    end
    wr(7, 0);
    for (int i = 0; i < DW; i++) begin
      step();
      if (Y === 8'hB0 || Y === 8'hA4) saw = 1;
    end
    cmp("abort_old_hidden", Y, 8'hBF);
    scan_lits(8'hF8, z, z, z);
    cmp("abort_no1234", saw, 0);

    // Reset mid-conversion.
    wr(99, 0);
    idle(7);
    cmp("pre_rst_busy", busy, 1);
    do_reset();
    cmp("rst_busy", busy, 0);
    cmp("rst_dig", DIG, 4'hF);
    cmp("rst_y", Y, 8'hFF);
    saw = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (DIG !== 4'hF || Y !== 8'hFF) saw = 1;
    end
    cmp("rst_stays_blank", saw, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int p;
      int sel;
      p = $urandom_range(0, 15);
      sel = $urandom_range(0, 2);
      wr_data = (sel == 0) ? DW'($urandom_range(0, 9999)) :
                (sel == 1) ? DW'($urandom_range(0, 65535)) : DW'($urandom);
      mode = $urandom_range(0, 1) != 0;
      cs = (p != 1) && (p < 4);
      wr_en = (p != 0) && (p < 4);
      if ($urandom_range(0, 299) == 0) begin
        cs = 0; wr_en = 0;
        do_reset();
      end else begin
        step();
      end
    end
    cs = 0; wr_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL provide parameter N_DIGITS, default 8, number of multiplexed 7-segment digits (1..8).
REQ-002 SHALL provide parameter DATA_W, default 32, width of the written value (4..32).
REQ-003 SHALL provide parameter SCAN_DIV, default 100000, clk cycles each digit stays enabled (>=2).
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  system clock; rst  input  1  async active-high reset.
REQ-005 SHALL have: cs  input  1  chip select from the memory-I/O decoder.
REQ-006 SHALL have: wr_en  input  1  write strobe; a write is accepted on a rising clk edge when cs && wr_en.
REQ-007 SHALL have: wr_data  input  DATA_W  unsigned value to display.
REQ-008 SHALL have: mode  input  1  sampled with the write; 0 = decimal, 1 = hexadecimal.
REQ-009 SHALL have: DIG  output  N_DIGITS  digit enables, active low, one-hot; DIG[0] = least significant digit.
REQ-010 SHALL have: Y  output  8  segments active low, Y[7] = dp (always 1), Y[6:0] = g..a.
REQ-011 SHALL have: busy  output  1  high while a decimal conversion is in progress.

Function
REQ-012 SHALL divide clk with a 0..SCAN_DIV-1 counter; on wrap the digit index advances, wrapping N_DIGITS-1 -> 0.
REQ-013 SHALL hold DIG all-ones and Y = 8'hFF until the first write completes, then scan continuously.
REQ-014 Hex write accepted at edge k SHALL update the display register at edge k+1; busy stays 0.
REQ-015 Decimal write accepted at edge k SHALL run iterative shift-add-3 (one bit per cycle), busy = 1 from edge k+1 through edge k+DATA_W, display register and busy = 0 updated atomically at edge k+DATA_W+1.
REQ-016 The displayed value SHALL never show a partially converted result; the old value stays until commit.
REQ-017 A write accepted while busy SHALL abort the running conversion and restart with the new data and mode.
REQ-018 Writes with cs = 0 or wr_en = 0 SHALL be ignored.
REQ-019 Decimal conversion SHALL use enough internal BCD digits to represent 2^DATA_W-1 exactly.
REQ-020 If any nonzero digit lies above N_DIGITS (decimal or hex), all digits SHALL display '-' (Y = 8'hBF).
REQ-021 Decoding SHALL cover 0-9 and A,b,C,d,E,F (Y: C0,F9,A4,B0,99,92,82,F8,80,90,88,83,C6,A1,86,8E).
REQ-022 DIG and Y SHALL be registered and change on the same edge; no combinational path from wr_data to outputs.

Reset
REQ-023 On rst: DIG = all ones, Y = 8'hFF, busy = 0, scan counter and index = 0, display register cleared, "written" flag cleared, conversion aborted.
REQ-024 Reset asserted mid-conversion SHALL discard the conversion; after release display stays blank until a new write completes.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN defined: zero digits above the most significant nonzero digit SHALL display blank (8'hFF); digit 0 always shown.
REQ-026 Macro LEADING_ZERO_BLANK_EN undefined: all N_DIGITS digits SHALL show their value including leading zeros (8'hC0).

Verification (N_DIGITS=4, DATA_W=17, SCAN_DIV=4)
REQ-027 Reset then idle 100 cycles -> DIG = 4'hF, Y = 8'hFF, busy = 0 throughout.
REQ-028 Decimal write 1234 at edge k -> busy high edges k+1..k+17, low at k+18; then DIG[0..3] scan showing Y = 99,B0,A4,F9, each digit for 4 cycles.
REQ-029 Hex write 17'h0BEEF -> at k+1 digits 0..3 show 8E,86,86,83, busy never asserted; decimal 12345 -> all digits 8'hBF.
REQ-030 Decimal write 1234, then write 7 at cycle k+5 -> 1234 never displayed; 7 commits at k+5+18; digit 0 = F8, digits 1..3 = FF with LEADING_ZERO_BLANK_EN, C0 without.
REQ-031 Decimal write 99 then rst pulse at k+8 -> busy drops immediately, DIG = 4'hF, Y = 8'hFF, display remains blank after release.
